rr_pio_arbiter: RTL and testbench
=================================

# rr_pio_arbiter

Round-robin arbiter and write sequencer that shares one 8-bit output PIO (Avalon-MM slave, register at address 0, zero wait states) between `NUM_REQ` requesters. It sits between the requesting logic and the PIO's slave port and issues single-cycle Avalon writes on the winners' behalf. After each write it enforces a minimum dwell so each value stays visible on the PIO output port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: requester data width; must be ≤ 32, normally equals the PIO width.
- `HOLD_CYCLES`, 16: minimum cycles between the end of one PIO write and the next arbitration. 0 is legal; 0..65535.
- `clk` in 1: single clock for the block and the PIO.
- `reset_n` in 1: active-low reset, synchronous to `clk`.
- `req` in NUM_REQ: level request per requester.
- `req_data` in NUM_REQ*DATA_W: requester i's value in bits [i*DATA_W +: DATA_W].
- `grant` out NUM_REQ: one-hot, one-cycle pulse marking the write cycle for the winner.
- `address` out 2: PIO address. Always 0.
- `chipselect` out 1: PIO chipselect.
- `write_n` out 1: PIO write strobe, active low.
- `writedata` out 32: {zero-extend, winner data}.
- `busy` out 1: high in WRITE or HOLD.
- `owner` out clog2(NUM_REQ): index of the last granted requester.

## Operation
- The FSM has three states: IDLE, WRITE, HOLD. Reset enters IDLE.
- **IDLE**
  - If `req` is nonzero, select the winner by round-robin, latch that requester's `req_data` into the data register, update `owner` and the pointer, and go to WRITE.
  - Otherwise stay in IDLE.
- **WRITE** (exactly 1 cycle)
  - Drive `chipselect=1`, `write_n=0`, `writedata={0, data_reg}`, and `grant[owner]=1`.
  - If `HOLD_CYCLES`=0, go to IDLE; otherwise load the dwell counter with `HOLD_CYCLES`-1 and go to HOLD.
- **HOLD**
  - Decrement the counter each cycle. When it reaches 0, go to IDLE. `req` is ignored.
- **Round-robin rule**
  - The pointer is the index after the last grant, mod `NUM_REQ`.
  - Search from the pointer upward with wrap. The first asserted `req` wins.
  - The pointer resets to 0, so requester 0 has top priority after reset.
- **Request protocol**
  - `req` and `req_data` are sampled only at the IDLE→WRITE edge.
  - A requester keeps `req` high until it sees its `grant` pulse, then drops `req` or keeps it high to request again.
  - A `req` withdrawn before the sampling edge is simply not served.
- Outside WRITE: `chipselect=0`, `write_n=1`, `writedata=0`, `grant=0`.
- The block never reads the PIO; `readdata` is not connected.

## Timing
- **Reset values** (on any edge where `reset_n`=0): state IDLE, `chipselect=0`, `write_n=1`, `address=0`, `writedata=0`, `grant=0`, `busy=0`, `owner=0`, pointer 0, counter 0, data register 0.
- **Reset mid-operation:**
  - Reset in WRITE aborts with no grant after the reset edge.
  - Reset in HOLD discards the remaining dwell.
  - The PIO's own register keeps whatever was already written.
- **Latency:** `req` high at IDLE edge k gives WRITE/`grant` in cycle k+1. The PIO output shows the new value after edge k+2.
- **Spacing:**
  - Grant-to-grant spacing under continuous requests is `HOLD_CYCLES`+2 cycles.
  - With `HOLD_CYCLES`=0 the spacing is 2 cycles, because IDLE is always one cycle.
- **Outputs:** all are registered; none is combinational from `req`.
- **Simultaneous events:** new `req` edges arriving during WRITE/HOLD wait for the next IDLE. When all requesters are asserted they are served in strict rotation.

## Test plan
- **Single request:** `HOLD_CYCLES`=4, `req`=0001 with data 0xA5 at edge 0.
  - One write pulse in cycle 1 with `writedata`=0x000000A5 and `grant`=0001.
  - `busy` is high for 5 cycles.
  - The PIO out_port reads 0xA5.
- **Full contention:** all four `req` held high, `HOLD_CYCLES`=2.
  - Grants occur in order 0,1,2,3,0,1 at 4-cycle spacing.
  - Each `writedata` matches the granted requester's data.
- **Pointer wrap:** grant requester 3 first (`req`=1000), then assert `req`=1001.
  - Next grant goes to requester 0, then 3 if both remain asserted.
- **HOLD_CYCLES=0 back-to-back:** `req`=0110 held.
  - Grants alternate 0010, 0100, 0010 every 2 cycles.
  - `chipselect` is never high on consecutive cycles.
- **Reset mid-HOLD:** pull `reset_n` low for 1 cycle in the 2nd HOLD cycle.
  - All outputs return to their reset values at that edge.
  - The next arbitration (`req`=1111) grants requester 0.
  - The PIO value from the earlier write persists.
- **Withdrawn request:** `req`[2] pulses for 1 cycle during HOLD.
  - No grant is issued to requester 2.
  - FSM returns to IDLE and stays idle with `chipselect`=0.

Source files
------------

// File: rtl/rr_pio_arbiter.sv
// rr_pio_arbiter
//   Shares one 8-bit Avalon-MM output PIO (register at address 0) between
//   NUM_REQ requesters. It picks a round-robin winner and issues a single-cycle
//   write on the winner's behalf. It then dwells for HOLD_CYCLES so the value
//   stays visible on the PIO output.
//
// Ports
//   clk, reset_n     : clock and synchronous active-low reset
//   req              : level request per requester
//   req_data         : requester i's value in bits [i*DATA_W +: DATA_W]
//   grant            : one-hot pulse marking the write cycle for the winner
//   address          : PIO address (constant 0)
//   chipselect       : PIO chipselect
//   write_n          : PIO write strobe (active low)
//   writedata        : zero-extended winner data
//   busy             : high while writing or dwelling
//   owner            : index of the last granted requester
//   state_dbg        : current FSM state (0 IDLE, 1 WRITE, 2 HOLD)
//
// Handshake: a requester holds req (and its req_data) until it sees its grant
// pulse. req/req_data are sampled only on the IDLE->WRITE edge. A request that
// is withdrawn before that edge is not served. During WRITE/HOLD, req is ignored.
module rr_pio_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [1:0]                 address,
    output logic                       chipselect,
    output logic                       write_n,
    output logic [31:0]                writedata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [1:0]                 state_dbg
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // The dwell counter counts HOLD_CYCLES-1 down to 0, so HOLD lasts HOLD_CYCLES cycles.
    localparam logic [15:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? 16'd0 : 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    idx;
    logic                found;
    logic                take;
    logic [DATA_W-1:0]   data_q;
    logic [15:0]         cnt_q;
    logic [NUM_REQ-1:0]  grant_d;
    logic [DATA_W-1:0]   req_arr [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_split
            assign req_arr[g] = req_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan upward from the pointer with wrap. The first asserted request wins.
    always_comb begin
        int sum;
        sum   = 0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
    end

    assign take = (state_q == S_IDLE) && found;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (found) state_d = S_WRITE;
            S_WRITE: state_d = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            S_HOLD:  if (cnt_q == 16'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            grant      <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            if (take) begin
                data_q     <= req_arr[win];
                owner      <= win;
                ptr_q      <= (win == LAST_IDX) ? '0 : win + 1'b1;
                grant      <= grant_d;
                chipselect <= 1'b1;
                write_n    <= 1'b0;
            end else begin
                grant      <= '0;
                chipselect <= 1'b0;
                write_n    <= 1'b1;
            end
            if (state_q == S_WRITE) begin
                cnt_q <= HOLD_LOAD;
            end else if (state_q == S_HOLD && cnt_q != 16'd0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Only flops feed writedata. The latched data is shown only while chipselect is high.
    always_comb begin
        writedata = '0;
        if (chipselect) begin
            writedata[DATA_W-1:0] = data_q;
        end
    end

    assign address   = 2'b00;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_pio_arbiter.sv
// Bench for rr_pio_arbiter. Three instances (HOLD_CYCLES 4, 2, 0) share one
// clock. A scoreboard queue holds {instance, grant, writedata} for each
// expected write cycle. Directed checks cover latency, spacing, reset and
// the pointer.
module tb_rr_pio_arbiter;

    localparam int SB_W = 2 + 4 + 32;

    logic        clk = 1'b0;
    logic        rst_w   [3];
    logic [3:0]  req_w   [3];
    logic [31:0] rdata_w [3];
    logic [3:0]  grant_w [3];
    logic [1:0]  addr_w  [3];
    logic        cs_w    [3];
    logic        wn_w    [3];
    logic [31:0] wd_w    [3];
    logic        busy_w  [3];
    logic [1:0]  own_w   [3];
    logic [1:0]  st_w    [3];

    logic [SB_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       pio_rst_n;
    logic [7:0] pio_out;

    always #5 clk = ~clk;

    rr_pio_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .reset_n(rst_w[0]), .req(req_w[0]), .req_data(rdata_w[0]),
        .grant(grant_w[0]), .address(addr_w[0]), .chipselect(cs_w[0]),
        .write_n(wn_w[0]), .writedata(wd_w[0]), .busy(busy_w[0]),
        .owner(own_w[0]), .state_dbg(st_w[0]));

    rr_pio_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .reset_n(rst_w[1]), .req(req_w[1]), .req_data(rdata_w[1]),
        .grant(grant_w[1]), .address(addr_w[1]), .chipselect(cs_w[1]),
        .write_n(wn_w[1]), .writedata(wd_w[1]), .busy(busy_w[1]),
        .owner(own_w[1]), .state_dbg(st_w[1]));

    rr_pio_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .reset_n(rst_w[2]), .req(req_w[2]), .req_data(rdata_w[2]),
        .grant(grant_w[2]), .address(addr_w[2]), .chipselect(cs_w[2]),
        .write_n(wn_w[2]), .writedata(wd_w[2]), .busy(busy_w[2]),
        .owner(own_w[2]), .state_dbg(st_w[2]));

    // PIO model on instance 0: its register is not touched by the arbiter reset.
    always @(posedge clk) begin
        if (!pio_rst_n) begin
            pio_out <= 8'h00;
        end else if (cs_w[0] && !wn_w[0] && addr_w[0] == 2'b00) begin
            pio_out <= wd_w[0][7:0];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write cycle on any instance must match the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cs_w[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_unexpected inst=%0d observed grant=%b data=0x%0h expected none",
                           k, grant_w[k], wd_w[k]);
                end else begin
                    check("sb_write", {2'(k), grant_w[k], wd_w[k]}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, "_cs"},    64'(cs_w[k]),    64'd0);
        check({tag, "_wn"},    64'(wn_w[k]),    64'd1);
        check({tag, "_addr"},  64'(addr_w[k]),  64'd0);
        check({tag, "_wd"},    64'(wd_w[k]),    64'd0);
        check({tag, "_grant"}, 64'(grant_w[k]), 64'd0);
        check({tag, "_busy"},  64'(busy_w[k]),  64'd0);
        check({tag, "_owner"}, 64'(own_w[k]),   64'd0);
        check({tag, "_state"}, 64'(st_w[k]),    64'd0);
    endtask

    task automatic wait_grant(input int k, input string tag);
        int n;
        n = 0;
        while (cs_w[k] !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check(tag, 64'(cs_w[k]), 64'd1);
    endtask

    task automatic wait_idle(input int k, input string tag);
        int n;
        n = 0;
        while (busy_w[k] !== 1'b0 && n < 50) begin
            tick;
            n++;
        end
        check(tag, 64'(busy_w[k]), 64'd0);
    endtask

    initial begin
        int busy_cnt, cs_cnt, g2_cnt, gcount, last_t, consec;
        logic prev_cs;

        pio_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rst_w[k]   = 1'b0;
            req_w[k]   = 4'b0000;
            rdata_w[k] = 32'h0;
        end
        tick; tick; tick;
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        check_reset(2, "rst2");
        pio_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) rst_w[k] = 1'b1;
        tick;

        // Single request on the HOLD_CYCLES=4 instance.
        rdata_w[0] = {8'h44, 8'h33, 8'h22, 8'hA5};
        req_w[0]   = 4'b0001;
        exp_q.push_back({2'd0, 4'b0001, 32'h0000_00A5});
        tick;
        check("single_cs", 64'(cs_w[0]), 64'd1);
        check("single_grant", 64'(grant_w[0]), 64'b0001);
        check("single_owner", 64'(own_w[0]), 64'd0);
        req_w[0] = 4'b0000;
        busy_cnt = 0;
        cs_cnt   = 0;
        for (int c = 0; c < 8; c++) begin
            if (busy_w[0]) busy_cnt++;
            if (cs_w[0]) cs_cnt++;
            tick;
        end
        check("single_busy_len", 64'(busy_cnt), 64'd5);
        check("single_cs_len", 64'(cs_cnt), 64'd1);
        check("single_pio", 64'(pio_out), 64'hA5);
        check("single_idle", 64'(st_w[0]), 64'd0);

        // Reset in the second HOLD cycle.
        rdata_w[0] = {8'h44, 8'h33, 8'h3C, 8'hA5};
        req_w[0]   = 4'b0010;
        exp_q.push_back({2'd0, 4'b0010, 32'h0000_003C});
        tick;
        check("rsthold_owner", 64'(own_w[0]), 64'd1);
        req_w[0] = 4'b0000;
        tick;
        tick;
        check("rsthold_in_hold", 64'(st_w[0]), 64'd2);
        rst_w[0] = 1'b0;
        tick;
        check_reset(0, "rsthold");
        check("rsthold_pio", 64'(pio_out), 64'h3C);
        rst_w[0] = 1'b1;
        rdata_w[0] = {8'h44, 8'h33, 8'h22, 8'hA5};
        req_w[0]   = 4'b1111;
        exp_q.push_back({2'd0, 4'b0001, 32'h0000_00A5});
        tick;
        check("rsthold_regrant", 64'(grant_w[0]), 64'b0001);
        req_w[0] = 4'b0000;
        wait_idle(0, "rsthold_idle");

        // Withdrawn request during HOLD.
        rdata_w[0] = {8'h77, 8'h33, 8'h22, 8'hA5};
        req_w[0]   = 4'b1000;
        exp_q.push_back({2'd0, 4'b1000, 32'h0000_0077});
        tick;
        check("withdraw_owner", 64'(own_w[0]), 64'd3);
        req_w[0] = 4'b0000;
        tick;
        req_w[0] = 4'b0100;
        tick;
        req_w[0] = 4'b0000;
        cs_cnt = 0;
        g2_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (cs_w[0]) cs_cnt++;
            if (grant_w[0][2]) g2_cnt++;
        end
        check("withdraw_no_write", 64'(cs_cnt), 64'd0);
        check("withdraw_no_grant2", 64'(g2_cnt), 64'd0);
        check("withdraw_idle", 64'(st_w[0]), 64'd0);
        check("withdraw_pio", 64'(pio_out), 64'h77);

        // Full contention on the HOLD_CYCLES=2 instance.
        rdata_w[1] = {8'h44, 8'h33, 8'h22, 8'h11};
        exp_q.push_back({2'd1, 4'b0001, 32'h11});
        exp_q.push_back({2'd1, 4'b0010, 32'h22});
        exp_q.push_back({2'd1, 4'b0100, 32'h33});
        exp_q.push_back({2'd1, 4'b1000, 32'h44});
        exp_q.push_back({2'd1, 4'b0001, 32'h11});
        exp_q.push_back({2'd1, 4'b0010, 32'h22});
        req_w[1] = 4'b1111;
        gcount = 0;
        last_t = 0;
        for (int n = 0; n < 60 && gcount < 6; n++) begin
            tick;
            if (cs_w[1]) begin
                if (gcount > 0) check("contend_spacing", 64'(cyc - last_t), 64'd4);
                last_t = cyc;
                gcount++;
                if (gcount == 6) req_w[1] = 4'b0000;
            end
        end
        check("contend_count", 64'(gcount), 64'd6);
        wait_idle(1, "contend_idle");

        // Pointer wrap: grant 3, then 0 and 3 both requesting.
        req_w[1] = 4'b1000;
        exp_q.push_back({2'd1, 4'b1000, 32'h44});
        wait_grant(1, "wrap_first");
        check("wrap_owner3", 64'(own_w[1]), 64'd3);
        req_w[1] = 4'b1001;
        exp_q.push_back({2'd1, 4'b0001, 32'h11});
        exp_q.push_back({2'd1, 4'b1000, 32'h44});
        tick;
        wait_grant(1, "wrap_second");
        check("wrap_grant0", 64'(grant_w[1]), 64'b0001);
        req_w[1] = 4'b1000;
        tick;
        wait_grant(1, "wrap_third");
        check("wrap_grant3", 64'(grant_w[1]), 64'b1000);
        req_w[1] = 4'b0000;
        wait_idle(1, "wrap_idle");

        // HOLD_CYCLES=0 back-to-back alternation.
        rdata_w[2] = {8'h00, 8'hC3, 8'h5A, 8'h00};
        exp_q.push_back({2'd2, 4'b0010, 32'h5A});
        exp_q.push_back({2'd2, 4'b0100, 32'hC3});
        exp_q.push_back({2'd2, 4'b0010, 32'h5A});
        req_w[2] = 4'b0110;
        gcount  = 0;
        last_t  = 0;
        consec  = 0;
        prev_cs = 1'b0;
        for (int n = 0; n < 40 && gcount < 3; n++) begin
            tick;
            if (cs_w[2] && prev_cs) consec++;
            prev_cs = cs_w[2];
            if (cs_w[2]) begin
                if (gcount > 0) check("h0_spacing", 64'(cyc - last_t), 64'd2);
                last_t = cyc;
                gcount++;
                if (gcount == 3) req_w[2] = 4'b0000;
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick;
            if (cs_w[2] && prev_cs) consec++;
            prev_cs = cs_w[2];
        end
        check("h0_count", 64'(gcount), 64'd3);
        check("h0_no_consecutive_cs", 64'(consec), 64'd0);
        check("h0_idle", 64'(st_w[2]), 64'd0);

        tick;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
